// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// ALU/mux select codes and the bundled control-output record.
package mc_pkg;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXE    = 4'd2;
  localparam logic [3:0] S_MEM    = 4'd3;
  localparam logic [3:0] S_ALUWB  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_R31 = 2'd2, RD_R30 = 2'd3;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_DM = 2'd1, M2R_PC = 2'd2, M2R_ONE = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;

  typedef enum logic [2:0] {C_ILL, C_ALU, C_JR, C_J, C_JAL, C_BEQ, C_LW, C_SW} cls_e;

  typedef struct packed {
    logic       imem_re;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_re;
    logic       mem_we;
    logic       bus_err;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/mc_if.sv
// Datapath-facing bundle: IR fields and flags in, control strobes out.
interface mc_if #(parameter int ALUOP_W = 3);
  logic [5:0]         opcode, funct;
  logic               zero, overflow, mem_ready;
  logic               imem_re, ir_we, pc_we, reg_we, alu_src;
  logic [1:0]         pc_sel, reg_dst, mem_to_reg, ext_op;
  logic [ALUOP_W-1:0] alu_op;
  logic               mem_re, mem_we, bus_err, illegal;
  logic [3:0]         state_o;

  modport master (
    output opcode, funct, zero, overflow, mem_ready,
    input  imem_re, ir_we, pc_we, pc_sel, reg_we, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, mem_re, mem_we, bus_err, illegal, state_o
  );
  modport slave (
    input  opcode, funct, zero, overflow, mem_ready,
    output imem_re, ir_we, pc_we, pc_sel, reg_we, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, mem_re, mem_we, bus_err, illegal, state_o
  );
endinterface

// File: rtl/mc_decode.sv
// Opcode/funct classifier: instruction class plus the ALU/extender setup
// that EXE, MEM and ALUWB all reuse.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output cls_e       o_cls,
  output logic       o_rtype,
  output logic       o_ovf_chk,
  output logic       o_alu_src,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_ext_op
);
  always_comb begin
    o_cls     = C_ILL;
    o_rtype   = 1'b0;
    o_ovf_chk = 1'b0;
    o_alu_src = 1'b0;
    o_alu_op  = ALU_ADD;
    o_ext_op  = EXT_ZERO;
    case (i_opcode)
      OP_RTYPE: begin
        o_rtype = 1'b1;
        case (i_funct)
          FN_ADDU: o_cls = C_ALU;
          FN_SUBU: begin o_cls = C_ALU; o_alu_op = ALU_SUB; end
          FN_ADD:  begin o_cls = C_ALU; o_ovf_chk = 1'b1; end
          FN_JR:   o_cls = C_JR;
          default: o_cls = C_ILL;
        endcase
      end
      OP_ORI:  begin o_cls = C_ALU; o_alu_src = 1'b1; o_alu_op = ALU_OR; end
      OP_LUI:  begin o_cls = C_ALU; o_alu_src = 1'b1; o_alu_op = ALU_LUI; o_ext_op = EXT_LUI; end
      OP_ADDI: begin o_cls = C_ALU; o_alu_src = 1'b1; o_ovf_chk = 1'b1; o_ext_op = EXT_SIGN; end
      OP_LW:   begin o_cls = C_LW;  o_alu_src = 1'b1; o_ext_op = EXT_SIGN; end
      OP_SW:   begin o_cls = C_SW;  o_alu_src = 1'b1; o_ext_op = EXT_SIGN; end
      OP_BEQ:  begin o_cls = C_BEQ; o_alu_op = ALU_SUB; o_ext_op = EXT_SIGN; end
      OP_J:    o_cls = C_J;
      OP_JAL:  o_cls = C_JAL;
      default: o_cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/write-back with a
// bounded wait on mem_ready; outputs are decoded from state and opcode.
module mc_controller
  import mc_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 15
) (
  input logic clk,
  input logic rst,
  mc_if.slave bus
);
  logic [3:0] r_state, w_nxt;
  logic [7:0] r_wait;
  logic       w_rdy, w_wait, w_to, w_alu_on;
  logic       w_rtype, w_ovf_chk, w_alu_src;
  logic [2:0] w_alu_op;
  logic [1:0] w_ext_op;
  cls_e       w_cls;
  ctrl_t      w_c, w_out;

  mc_decode u_dec (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_cls    (w_cls),
    .o_rtype  (w_rtype),
    .o_ovf_chk(w_ovf_chk),
    .o_alu_src(w_alu_src),
    .o_alu_op (w_alu_op),
    .o_ext_op (w_ext_op)
  );

  assign w_rdy    = (MEM_HANDSHAKE == 0) || bus.mem_ready;
  assign w_wait   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !w_rdy;
  assign w_to     = w_wait && (r_wait == 8'(TIMEOUT - 1));
  assign w_alu_on = (r_state == S_EXE) || (r_state == S_MEM) || (r_state == S_ALUWB);

  always_comb begin
    w_c   = '0;
    w_nxt = r_state;
    // ALU/extender setup stays stable from EXE through the access or write-back
    if (w_alu_on) begin
      w_c.alu_op  = w_alu_op;
      w_c.alu_src = w_alu_src;
      w_c.ext_op  = w_ext_op;
    end
    case (r_state)
      S_FETCH: begin
        w_c.imem_re = 1'b1;
        if (w_rdy) begin
          w_c.ir_we = 1'b1;
          w_c.pc_we = 1'b1;
          w_nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_nxt = S_FETCH;
        case (w_cls)
          C_J:   begin w_c.pc_we = 1'b1; w_c.pc_sel = PC_JMP; end
          C_JR:  begin w_c.pc_we = 1'b1; w_c.pc_sel = PC_RS; end
          C_JAL: begin
            w_c.pc_we      = 1'b1;
            w_c.pc_sel     = PC_JMP;
            w_c.reg_we     = 1'b1;
            w_c.reg_dst    = RD_R31;
            w_c.mem_to_reg = M2R_PC;
          end
          C_ILL:   w_c.illegal = 1'b1;
          default: w_nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        if (w_cls == C_BEQ) begin
          w_c.pc_we  = bus.zero;
          w_c.pc_sel = PC_BR;
          w_nxt      = S_FETCH;
        end else if ((w_cls == C_LW) || (w_cls == C_SW)) w_nxt = S_MEM;
        else w_nxt = S_ALUWB;
      end
      S_MEM: begin
        w_c.mem_re = (w_cls == C_LW);
        w_c.mem_we = (w_cls == C_SW);
        if (w_rdy) w_nxt = (w_cls == C_LW) ? S_MEMWB : S_FETCH;
      end
      S_ALUWB: begin
        w_c.reg_we  = 1'b1;
        w_c.reg_dst = w_rtype ? RD_RD : RD_RT;
        // signed overflow redirects the write to $30 <= 1 instead of rd/rt
        if (w_ovf_chk && bus.overflow) begin
          w_c.reg_dst    = RD_R30;
          w_c.mem_to_reg = M2R_ONE;
        end
        w_nxt = S_FETCH;
      end
      S_MEMWB: begin
        w_c.reg_we     = 1'b1;
        w_c.mem_to_reg = M2R_DM;
        w_nxt          = S_FETCH;
      end
      default: w_nxt = S_FETCH;
    endcase
    if (w_to) begin
      w_c.bus_err = 1'b1;
      w_nxt       = S_FETCH;
    end
  end

  assign w_out = rst ? '0 : w_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_nxt;
      r_wait  <= (w_wait && !w_to) ? r_wait + 8'd1 : 8'd0;
    end
  end

  assign bus.imem_re    = w_out.imem_re;
  assign bus.ir_we      = w_out.ir_we;
  assign bus.pc_we      = w_out.pc_we;
  assign bus.pc_sel     = w_out.pc_sel;
  assign bus.reg_we     = w_out.reg_we;
  assign bus.reg_dst    = w_out.reg_dst;
  assign bus.mem_to_reg = w_out.mem_to_reg;
  assign bus.alu_src    = w_out.alu_src;
  assign bus.alu_op     = ALUOP_W'(w_out.alu_op);
  assign bus.ext_op     = w_out.ext_op;
  assign bus.mem_re     = w_out.mem_re;
  assign bus.mem_we     = w_out.mem_we;
  assign bus.bus_err    = w_out.bus_err;
  assign bus.illegal    = w_out.illegal;
  assign bus.state_o    = rst ? S_FETCH : r_state;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: decode table, hand-written corner sequences and
// randomized instructions with random stalls against a per-instruction model.
module tb_mc_controller;
  localparam int T = 4;

  typedef struct packed {
    logic imem_re, ir_we, pc_we; logic [1:0] pc_sel; logic reg_we;
    logic [1:0] reg_dst, m2r; logic alu_src; logic [2:0] alu_op; logic [1:0] ext_op;
    logic mem_re, mem_we, bus_err, illegal; logic [3:0] st;
  } smp_t;
  typedef struct {
    logic [5:0] op, fn; int lat; logic chk; logic [2:0] aop; logic src; logic [1:0] ext;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  smp_t tr [16];
  vec_t tv [13];
  logic [11:0] pool [15];

  always #5 clk = ~clk;

  mc_if #(.ALUOP_W(3)) bus ();
  mc_controller #(.ALUOP_W(3), .MEM_HANDSHAKE(1), .TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic smp_t sample();
    return {bus.imem_re, bus.ir_we, bus.pc_we, bus.pc_sel, bus.reg_we, bus.reg_dst,
            bus.mem_to_reg, bus.alu_src, bus.alu_op, bus.ext_op, bus.mem_re, bus.mem_we,
            bus.bus_err, bus.illegal, bus.state_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, fn, input logic z, ov);
    bus.opcode = op; bus.funct = fn; bus.zero = z; bus.overflow = ov;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // one sample per cycle; rdy[i] is mem_ready during cycle i
  task automatic trace(input logic [5:0] op, fn, input logic z, ov, input logic [15:0] rdy, input int n);
    set_in(op, fn, z, ov);
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      tr[i] = sample();
      tick();
    end
  endtask

  // Model: cycle count and architectural effects of one instruction given
  // fetch stall sf and memory stall sm (stall >= T means the wait times out).
  task automatic run_rand(input int idx, input logic [5:0] op, fn, input logic z, ov, input int sf, sm);
    int kind, cyc, fcyc, mcyc, fr, wf, wm;
    int e_pcx, e_sel, e_reg, e_dst, e_m2r, e_ill, e_be;
    int n_ir, n_pc0, n_pcx, sel, n_reg, dst, m2r, n_ill, n_be;
    logic rt, ovi, mto;
    smp_t s;
    string nm;
    rt  = (op == 6'd0);
    ovi = (rt && fn == 6'b100000) || (op == 6'b001000);
    case (op)
      6'b000000: case (fn)
        6'b100001, 6'b100011, 6'b100000: kind = 1;
        6'b001000: kind = 2;
        default:   kind = 0;
      endcase
      6'b001101, 6'b001111, 6'b001000: kind = 1;
      6'b000010: kind = 3;
      6'b000011: kind = 4;
      6'b000100: kind = 5;
      6'b100011: kind = 6;
      6'b101011: kind = 7;
      default:   kind = 0;
    endcase
    fcyc = (sf >= T) ? T + 1 : sf + 1;
    fr   = (sf >= T) ? T : sf;
    mto  = (sm >= T);
    mcyc = mto ? T : sm + 1;
    e_be = (sf >= T) ? 1 : 0;
    e_pcx = 0; e_sel = 0; e_reg = 0; e_dst = 0; e_m2r = 0; e_ill = 0;
    case (kind)
      0: begin cyc = fcyc + 1; e_ill = 1; end
      2: begin cyc = fcyc + 1; e_pcx = 1; e_sel = 3; end
      3: begin cyc = fcyc + 1; e_pcx = 1; e_sel = 2; end
      4: begin cyc = fcyc + 1; e_pcx = 1; e_sel = 2; e_reg = 1; e_dst = 2; e_m2r = 2; end
      5: begin cyc = fcyc + 2; if (z) begin e_pcx = 1; e_sel = 1; end end
      1: begin
        cyc = fcyc + 3; e_reg = 1;
        if (ovi && ov) begin e_dst = 3; e_m2r = 3; end
        else e_dst = rt ? 1 : 0;
      end
      6: begin
        cyc = fcyc + 2 + mcyc + (mto ? 0 : 1);
        e_be += mto ? 1 : 0;
        if (!mto) begin e_reg = 1; e_m2r = 1; end
      end
      default: begin cyc = fcyc + 2 + mcyc; e_be += mto ? 1 : 0; end
    endcase
    n_ir = 0; n_pc0 = 0; n_pcx = 0; sel = 0; n_reg = 0; dst = 0; m2r = 0; n_ill = 0; n_be = 0;
    wf = 0; wm = 0;
    set_in(op, fn, z, ov);
    #1;
    for (int i = 0; i < cyc; i++) begin
      if (bus.imem_re) begin bus.mem_ready = (wf == fr); wf++; end
      else if (bus.mem_re || bus.mem_we) begin bus.mem_ready = (wm == sm); wm++; end
      else bus.mem_ready = 1'($urandom);
      #1;
      s = sample();
      if (s.ir_we) n_ir++;
      if (s.pc_we && s.pc_sel == 2'd0) n_pc0++;
      if (s.pc_we && s.pc_sel != 2'd0) begin n_pcx++; sel = s.pc_sel; end
      if (s.reg_we) begin n_reg++; dst = s.reg_dst; m2r = s.m2r; end
      if (s.illegal) n_ill++;
      if (s.bus_err) n_be++;
      @(posedge clk);
      #1;
    end
    nm = $sformatf("rand%0d op=%b fn=%b z=%0b ov=%0b sf=%0d sm=%0d", idx, op, fn, z, ov, sf, sm);
    chk({nm, " flow"}, {bus.state_o, 4'(n_ir), 4'(n_pc0), 4'(n_pcx), 4'(n_ill), 4'(n_be)},
        {4'd0, 4'd1, 4'd1, 4'(e_pcx), 4'(e_ill), 4'(e_be)});
    chk({nm, " wb"}, {4'(sel), 4'(n_reg), 4'(dst), 4'(m2r)},
        {4'(e_sel), 4'(e_reg), 4'(e_dst), 4'(e_m2r)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{6'b000000, 6'b100001, 4, 1'b1, 3'd0, 1'b0, 2'd0};
    tv[1]  = '{6'b000000, 6'b100011, 4, 1'b1, 3'd1, 1'b0, 2'd0};
    tv[2]  = '{6'b000000, 6'b100000, 4, 1'b1, 3'd0, 1'b0, 2'd0};
    tv[3]  = '{6'b000000, 6'b001000, 2, 1'b0, 3'd0, 1'b0, 2'd0};
    tv[4]  = '{6'b001101, 6'b010101, 4, 1'b1, 3'd2, 1'b1, 2'd0};
    tv[5]  = '{6'b001111, 6'b000000, 4, 1'b1, 3'd3, 1'b1, 2'd2};
    tv[6]  = '{6'b001000, 6'b111111, 4, 1'b1, 3'd0, 1'b1, 2'd1};
    tv[7]  = '{6'b100011, 6'b000000, 5, 1'b1, 3'd0, 1'b1, 2'd1};
    tv[8]  = '{6'b101011, 6'b000000, 4, 1'b1, 3'd0, 1'b1, 2'd1};
    tv[9]  = '{6'b000100, 6'b000000, 3, 1'b1, 3'd1, 1'b0, 2'd1};
    tv[10] = '{6'b000010, 6'b000000, 2, 1'b0, 3'd0, 1'b0, 2'd0};
    tv[11] = '{6'b000011, 6'b000000, 2, 1'b0, 3'd0, 1'b0, 2'd0};
    tv[12] = '{6'b000000, 6'b000000, 2, 1'b0, 3'd0, 1'b0, 2'd0};
    pool = '{12'b000000_100001, 12'b000000_100011, 12'b000000_100000, 12'b000000_001000,
             12'b001101_000000, 12'b001111_000000, 12'b001000_000000, 12'b100011_000000,
             12'b101011_000000, 12'b000100_000000, 12'b000010_000000, 12'b000011_000000,
             12'b111111_000000, 12'b000000_000001, 12'b000101_000000};

    // reset: outputs forced low even with live inputs
    set_in(6'b100011, 6'd0, 1'b1, 1'b1);
    bus.mem_ready = 1'b1;
    tick();
    chk("reset_outs", 32'(sample()), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_fetch", {bus.imem_re, bus.state_o}, {1'b1, 4'd0});

    // decode table with mem_ready always high
    for (int k = 0; k < 13; k++) begin
      trace(tv[k].op, tv[k].fn, 1'b0, 1'b0, 16'hFFFF, tv[k].lat);
      if (tv[k].chk)
        chk($sformatf("tbl%0d alu", k), {tr[2].alu_op, tr[2].alu_src, tr[2].ext_op},
            {tv[k].aop, tv[k].src, tv[k].ext});
      chk($sformatf("tbl%0d latency", k), {bus.state_o, 1'(tr[tv[k].lat-1].st != 4'd0)}, {4'd0, 1'b1});
    end

    // addu: F D E ALUWB, single write in cycle 4
    do_reset();
    trace(6'b000000, 6'b100001, 1'b0, 1'b0, 16'hFFFF, 4);
    chk("addu_states", {tr[0].st, tr[1].st, tr[2].st, tr[3].st}, 16'h0124);
    chk("addu_regwe", {tr[0].reg_we, tr[1].reg_we, tr[2].reg_we, tr[3].reg_we}, 4'b0001);
    chk("addu_wb", {tr[3].reg_dst, tr[3].m2r, bus.state_o}, {2'd1, 2'd0, 4'd0});

    // lw, mem_ready low 3 cycles in MEM
    trace(6'b100011, 6'd0, 1'b0, 1'b0, 16'h00C7, 8);
    chk("lw_memre_cycles", 32'(tr[3].mem_re + tr[4].mem_re + tr[5].mem_re + tr[6].mem_re + tr[7].mem_re), 32'd4);
    chk("lw_memwb", {tr[7].st, tr[7].reg_we, tr[7].reg_dst, tr[7].m2r}, {4'd5, 1'b1, 2'd0, 2'd1});
    chk("lw_done", bus.state_o, 4'd0);

    // beq taken / not taken
    trace(6'b000100, 6'd0, 1'b1, 1'b0, 16'hFFFF, 3);
    chk("beq_taken", {tr[2].pc_we, tr[2].pc_sel, bus.state_o}, {1'b1, 2'd1, 4'd0});
    trace(6'b000100, 6'd0, 1'b0, 1'b0, 16'hFFFF, 3);
    chk("beq_not_taken", {tr[2].pc_we, bus.state_o}, {1'b0, 4'd0});

    // jal: all link effects in DECODE
    trace(6'b000011, 6'd0, 1'b0, 1'b0, 16'hFFFF, 2);
    chk("jal_decode", {tr[1].pc_we, tr[1].pc_sel, tr[1].reg_we, tr[1].reg_dst, tr[1].m2r, bus.state_o},
        {1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 4'd0});

    // addi overflow writes $30 <= 1
    trace(6'b001000, 6'd0, 1'b0, 1'b1, 16'hFFFF, 4);
    chk("addi_ovf", {tr[3].reg_we, tr[3].reg_dst, tr[3].m2r}, {1'b1, 2'd3, 2'd3});

    // fetch timeout: bus_err on 4th wait cycle, no PC/IR write
    trace(6'b000010, 6'd0, 1'b0, 1'b0, 16'h0000, 4);
    chk("fetch_to_berr", {tr[0].bus_err, tr[1].bus_err, tr[2].bus_err, tr[3].bus_err}, 4'b0001);
    chk("fetch_to_nowr", {tr[0].pc_we | tr[1].pc_we | tr[2].pc_we | tr[3].pc_we,
                          tr[0].ir_we | tr[1].ir_we | tr[2].ir_we | tr[3].ir_we, bus.state_o}, {2'b00, 4'd0});

    // illegal opcode
    trace(6'b111111, 6'd0, 1'b0, 1'b0, 16'hFFFF, 2);
    chk("illegal_pulse", {tr[0].illegal, tr[1].illegal, tr[1].pc_we, tr[1].reg_we, tr[1].mem_we, bus.state_o},
        {1'b0, 1'b1, 3'b000, 4'd0});

    // rst in the middle of a stalled sw
    trace(6'b101011, 6'd0, 1'b0, 1'b0, 16'h0007, 5);
    chk("rst_pre_mem", {tr[4].st, tr[4].mem_we}, {4'd3, 1'b1});
    rst = 1'b1;
    #1;
    chk("rst_comb_outs", 32'(sample()), 32'd0);
    tick();
    chk("rst_outs", 32'(sample()), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_fetch", {bus.state_o, bus.imem_re, bus.mem_we}, {4'd0, 1'b1, 1'b0});

    // randomized instructions with random stalls
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [11:0] p;
      logic [5:0]  fn;
      p  = pool[$urandom_range(0, 14)];
      fn = (p[11:6] == 6'd0) ? p[5:0] : 6'($urandom);
      run_rand(n, p[11:6], fn, 1'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational decoder with an FSM that sequences fetch, decode, execute, memory and write-back over several cycles. It drives the shared datapath (ifu, gpr, alu, ext, dm, muxes) and honours a memory ready handshake with timeout.

Parameters:
ALUOP_W, 3, width of alu_op
MEM_HANDSHAKE, 1, 1 = wait on mem_ready; 0 = mem_ready treated as constant 1
TIMEOUT, 15, max wait cycles for mem_ready before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
overflow  in  1  ALU signed-overflow flag
mem_ready  in  1  imem/dm access complete this cycle
imem_re  out  1  instruction read request
ir_we  out  1  latch IR
pc_we  out  1  PC write enable
pc_sel  out  2  0 PC+4, 1 branch target, 2 j target, 3 rs (jr)
reg_we  out  1  GPR write enable
reg_dst  out  2  0 rt, 1 rd, 2 $31, 3 $30
mem_to_reg  out  2  0 ALU, 1 DM, 2 PC, 3 constant 1
alu_src  out  1  0 rt data, 1 ext32
alu_op  out  ALUOP_W  ALU function
ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
mem_re  out  1  DM read request
mem_we  out  1  DM write request
bus_err  out  1  one-cycle pulse on timeout
illegal  out  1  one-cycle pulse on unknown opcode/funct
state_o  out  4  current state (debug)

Behaviour:
- Reset: sync; state=FETCH, wait counter=0; while rst=1 all outputs 0 (state_o=FETCH).
- Outputs are combinational from state, opcode and funct (Moore-style, plus opcode decode); inactive signals are 0.
- ISA: R-type (opcode 0) addu 100001, subu 100011, add 100000, jr 001000; ori 001101, lui 001111, addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH: imem_re=1. On mem_ready: ir_we=1, pc_we=1, pc_sel=0, go to DECODE.
- DECODE:
  - j: pc_we, pc_sel=2, go to FETCH.
  - jal: pc_we, pc_sel=2, reg_we, reg_dst=2, mem_to_reg=2 (PC already holds old PC+4), go to FETCH.
  - jr: pc_we, pc_sel=3, go to FETCH.
  - Unknown opcode/funct: illegal=1, go to FETCH with no writes.
  - Otherwise go to EXE.
- EXE:
  - beq: alu_op=SUB, alu_src=0; pc_we=zero, pc_sel=1, ext_op=1; go to FETCH.
  - lw/sw: alu_op=ADD, alu_src=1, ext_op=1; go to MEM.
  - Other: drive ALU controls; go to ALUWB.
- ALUWB: reg_we=1, mem_to_reg=0, alu controls held. reg_dst=1 for R-type, 0 for I-type.
  - add/addi with overflow=1: reg_dst=3, mem_to_reg=3 ($30 <= 1); rd/rt not written.
  - Go to FETCH.
- MEM:
  - lw: mem_re=1; on mem_ready go to MEMWB.
  - sw: mem_we=1; on mem_ready go to FETCH.
  - Address controls are held throughout MEM.
- MEMWB: reg_we, reg_dst=0, mem_to_reg=1; go to FETCH.
- Wait counter:
  - Increments each FETCH/MEM cycle without mem_ready; clears on state change.
  - Reaching TIMEOUT: bus_err=1 for one cycle, go to FETCH.
  - FETCH timeout: no pc_we (refetch same PC). MEM timeout: instruction abandoned, no write.
- Latency with mem_ready=1: j/jal/jr 2 cycles, beq 3, R/I ALU 4, sw 4, lw 5.
- rst in any state: abandons the instruction; no write is issued in the reset cycle.

Decomposition:
- Package mc_pkg: state encoding (FETCH, DECODE, EXE, MEM, ALUWB, MEMWB), opcode/funct constants, ALU op codes (ADD=0, SUB=1, OR=2, LUI=3), pc_sel/reg_dst/mem_to_reg/ext_op codes.
- Sub-module mc_decode: combinational opcode/funct -> instruction class and ALU/ext controls; FSM stays in mc_controller.

Test Plan:
- addu $3,$1,$2, mem_ready=1 -> states FETCH, DECODE, EXE, ALUWB; reg_we=1 only in cycle 4 with reg_dst=1, mem_to_reg=0.
- lw with mem_ready low 3 cycles in MEM -> mem_re held 4 cycles, then MEMWB reg_we=1, mem_to_reg=1; total 8 cycles.
- beq zero=1 then zero=0 -> pc_we=1/pc_sel=1 in EXE first case; pc_we=0 in EXE second; both return to FETCH after 3 cycles.
- jal -> DECODE asserts pc_we, pc_sel=2, reg_we, reg_dst=2, mem_to_reg=2 in the same cycle; next cycle FETCH.
- addi with overflow=1 in ALUWB -> reg_dst=3, mem_to_reg=3, reg_we=1.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err pulse on 4th wait cycle, no pc_we, then FETCH again.
- opcode 111111 -> illegal pulse in DECODE, no writes.
- rst asserted mid-MEM -> outputs 0 and state_o=FETCH next cycle.
